// File: rtl/sseg4_scan_ctrl.sv
// Scan controller for the 4-digit seven-segment driver. It steps digit_sel through
// 0..3 at a programmable slot rate, blanks the anodes at each slot start, and swaps
// the double-buffered display word only at frame boundaries.
module sseg4_scan_ctrl #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        upd_req,
  input  logic [15:0] upd_data,
  output logic        upd_ack,
  output logic [15:0] frame_data,
  output logic [1:0]  digit_sel,
  output logic        an_en,
  output logic        frame_tick
);

  localparam int unsigned   CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          slot_end;
  logic          boundary;
  logic          accept;

  always_comb begin
    slot_end = (cnt == CNT_MAX);
    boundary = (state == SCAN) && slot_end && (digit_sel == 2'd3);
    // Updates are taken whenever the display is dark; while scanning only at the frame edge.
    accept   = upd_req && ((state == IDLE) || !en || boundary);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_sel  <= '0;
      frame_data <= '0;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      upd_ack    <= accept;
      if (accept) begin
        frame_data <= upd_data;
      end
      case (state)
        IDLE: begin
          cnt       <= '0;
          digit_sel <= '0;
          if (en) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!en) begin
            state     <= IDLE;
            cnt       <= '0;
            digit_sel <= '0;
          end else if (slot_end) begin
            cnt       <= '0;
            digit_sel <= digit_sel + 2'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          digit_sel <= '0;
        end
      endcase
    end
  end

  // A zero blank length would make the threshold compare trivially true.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign an_en = (state == SCAN);
    end else begin : g_blank
      assign an_en = (state == SCAN) && (cnt >= CW'(BLANK));
    end
  endgenerate

endmodule

// File: tb/tb_sseg4_scan_ctrl.sv
// Table-driven bench for sseg4_scan_ctrl: a DIV=8/BLANK=2 instance for the main scan,
// update, abort and async reset cases, and a DIV=2/BLANK=0 instance for edge parameters.
module tb_sseg4_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, upd_req;
  logic [15:0] upd_data;
  logic        upd_ack, an_en, frame_tick;
  logic [15:0] frame_data;
  logic [1:0]  digit_sel;

  logic        en2, upd_req2;
  logic [15:0] upd_data2;
  logic        upd_ack2, an_en2, frame_tick2;
  logic [15:0] frame_data2;
  logic [1:0]  digit_sel2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sseg4_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd_req(upd_req), .upd_data(upd_data),
    .upd_ack(upd_ack), .frame_data(frame_data), .digit_sel(digit_sel),
    .an_en(an_en), .frame_tick(frame_tick)
  );

  sseg4_scan_ctrl #(.DIV(2), .BLANK(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .upd_req(upd_req2), .upd_data(upd_data2),
    .upd_ack(upd_ack2), .frame_data(frame_data2), .digit_sel(digit_sel2),
    .an_en(an_en2), .frame_tick(frame_tick2)
  );

  typedef struct {
    logic        unit;
    logic        en;
    logic        req;
    logic [15:0] data;
    logic [1:0]  dig;
    logic        an;
    logic        tick;
    logic        ack;
    logic [15:0] fd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic unit, input logic e, input logic r,
                              input logic [15:0] d, input logic [1:0] dg,
                              input logic a, input logic t, input logic k,
                              input logic [15:0] f);
    vec_t v;
    v.unit = unit; v.en = e; v.req = r; v.data = d;
    v.dig = dg; v.an = a; v.tick = t; v.ack = k; v.fd = f;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input logic unit, input int idx, input logic [1:0] dg,
                         input logic a, input logic t, input logic k,
                         input logic [15:0] f);
    if (!unit) begin
      chk("digit_sel", idx, 16'(digit_sel), 16'(dg));
      chk("an_en", idx, 16'(an_en), 16'(a));
      chk("frame_tick", idx, 16'(frame_tick), 16'(t));
      chk("upd_ack", idx, 16'(upd_ack), 16'(k));
      chk("frame_data", idx, frame_data, f);
    end else begin
      chk("digit_sel2", idx, 16'(digit_sel2), 16'(dg));
      chk("an_en2", idx, 16'(an_en2), 16'(a));
      chk("frame_tick2", idx, 16'(frame_tick2), 16'(t));
      chk("upd_ack2", idx, 16'(upd_ack2), 16'(k));
      chk("frame_data2", idx, frame_data2, f);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    if (!v.unit) begin
      en = v.en; upd_req = v.req; upd_data = v.data;
    end else begin
      en2 = v.en; upd_req2 = v.req; upd_data2 = v.data;
    end
    @(posedge clk);
    #1;
    chk_all(v.unit, idx, v.dig, v.an, v.tick, v.ack, v.fd);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; upd_req = 1'b0; upd_data = '0;
    en2 = 1'b0; upd_req2 = 1'b0; upd_data2 = '0;

    // Phase A: DIV=8, BLANK=2
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0));
    for (int k = 0; k < 150; k++) begin
      tbl.push_back(mk(0, 1, (k >= 108 && k <= 128), 16'h1234, 2'((k / 8) % 4),
                       (k % 8) >= 2, (k > 0 && k % 32 == 0), (k == 128),
                       (k >= 128) ? 16'h1234 : 16'h0000));
    end
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h1234));
    for (int j = 0; j < 10; j++)
      tbl.push_back(mk(0, 1, 0, 16'h0, 2'(j / 8), (j % 8) >= 2, 0, 0, 16'h1234));
    tbl.push_back(mk(0, 0, 0, 16'h0,    0, 0, 0, 0, 16'h1234));
    tbl.push_back(mk(0, 0, 1, 16'hBEEF, 0, 0, 0, 1, 16'hBEEF));
    tbl.push_back(mk(0, 0, 0, 16'h0,    0, 0, 0, 0, 16'hBEEF));
    tbl.push_back(mk(0, 0, 0, 16'h0,    0, 0, 0, 0, 16'hBEEF));
    for (int j = 0; j < 5; j++) tbl.push_back(mk(0, 1, 0, 16'h0, 0, j >= 2, 0, 0, 16'hBEEF));

    @(posedge clk);
    #1;
    chk_all(0, -1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk_all(1, -1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Async reset in the middle of a slot, away from any clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(0, 1000, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    chk_all(0, 1001, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    apply(mk(0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0), 1002);
    apply(mk(0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0), 1003);

    // Phase B: DIV=2, BLANK=0, update request held high across boundaries
    tbl.delete();
    for (int k = 0; k < 24; k++) begin
      tbl.push_back(mk(1, 1, 1, 16'h1000 + 16'(k), 2'((k / 2) % 4), 1,
                       (k > 0 && k % 8 == 0), (k % 8 == 0), 16'h1000 + 16'((k / 8) * 8)));
    end
    // Boundary coinciding with en falling: latch and tick still happen
    tbl.push_back(mk(1, 0, 1, 16'h2024, 0, 0, 1, 1, 16'h2024));
    tbl.push_back(mk(1, 0, 0, 16'h0,    0, 0, 0, 0, 16'h2024));
    foreach (tbl[i]) apply(tbl[i], 2000 + i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
